// File: rtl/reg_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter_if
// Brief    : Writer A/B req/gnt handshake, read port and status bundle
// Revision : 1.0 - initial release
// ============================================================================
interface reg_bank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             ReqA;
    logic [AW-1:0]    AddrA;
    logic [WIDTH-1:0] DataA;
    logic             GntA;
    logic             ReqB;
    logic [AW-1:0]    AddrB;
    logic [WIDTH-1:0] DataB;
    logic             GntB;
    logic [AW-1:0]    RdAddr;
    logic [WIDTH-1:0] RdData;
    logic             Busy;

    modport master (
        output ReqA, AddrA, DataA, ReqB, AddrB, DataB, RdAddr,
        input  GntA, GntB, RdData, Busy
    );

    modport slave (
        input  ReqA, AddrA, DataA, ReqB, AddrB, DataB, RdAddr,
        output GntA, GntB, RdData, Busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter
// Brief    : Two-writer round-robin arbiter over a DEPTH x WIDTH register bank
//            with one write per grant. Optional write counter: REG_BANK_WRCOUNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire             Clk,
    input  wire             Resetn,
`ifdef REG_BANK_WRCOUNT_EN
    output logic [7:0]      WrCount,
`endif
    reg_bank_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT_A = 3'd1,
        S_WAIT_A  = 3'd2,
        S_GRANT_B = 3'd3,
        S_WAIT_B  = 3'd4
    } state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];
    logic             wr_fire;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bank_d  = bank_q;
        wr_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                // On contention the side that did not write last wins.
                if (bus.ReqA && (!bus.ReqB || last_q == LAST_B))
                    state_d = S_GRANT_A;
                else if (bus.ReqB)
                    state_d = S_GRANT_B;
            end
            S_GRANT_A: begin
                bank_d[bus.AddrA] = bus.DataA;
                last_d            = LAST_A;
                wr_fire           = 1'b1;
                state_d           = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (!bus.ReqA)
                    state_d = S_IDLE;
            end
            S_GRANT_B: begin
                bank_d[bus.AddrB] = bus.DataB;
                last_d            = LAST_B;
                wr_fire           = 1'b1;
                state_d           = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (!bus.ReqB)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered images of the next state.
        gnt_a_d = (state_d == S_GRANT_A) || (state_d == S_WAIT_A);
        gnt_b_d = (state_d == S_GRANT_B) || (state_d == S_WAIT_B);
        busy_d  = (state_d != S_IDLE);
    end

`ifdef REG_BANK_WRCOUNT_EN
    logic [7:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_fire)
            wr_count_d = wr_count_q + 8'd1;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn)
            wr_count_q <= 8'd0;
        else
            wr_count_q <= wr_count_d;
    end

    assign WrCount = wr_count_q;
`else
    logic unused_wr_fire;
    assign unused_wr_fire = wr_fire;
`endif

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            last_q  <= LAST_B;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
            bank_q  <= bank_d;
        end
    end

    assign bus.GntA   = gnt_a_q;
    assign bus.GntB   = gnt_b_q;
    assign bus.Busy   = busy_q;
    assign bus.RdData = bank_q[bus.RdAddr];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_arbiter
// Brief    : Directed + randomized bench for reg_bank_arbiter against a
//            transaction-level ownership model
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;

    logic Clk;
    logic Resetn;

    reg_bank_arbiter_if #(.WIDTH(8), .AW(2)) bus ();

`ifdef REG_BANK_WRCOUNT_EN
    logic [7:0] WrCount;
`endif

    reg_bank_arbiter #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .Clk     (Clk),
        .Resetn  (Resetn),
`ifdef REG_BANK_WRCOUNT_EN
        .WrCount (WrCount),
`endif
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the bank (0 none, 1 A, 2 B), whether its one write is done.
    int         m_owner;
    bit         m_written;
    int         m_last;
    logic [7:0] m_bank [4];
    int         m_count;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_written = 0;
        m_last    = 2;
        m_count   = 0;
        for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
    endtask

    task automatic check_outputs();
        check_eq("GntA", {31'd0, bus.GntA}, {31'd0, m_owner == 1});
        check_eq("GntB", {31'd0, bus.GntB}, {31'd0, m_owner == 2});
        check_eq("Busy", {31'd0, bus.Busy}, {31'd0, m_owner != 0});
        check_eq("excl", {31'd0, bus.GntA & bus.GntB}, 32'd0);
        check_eq("RdData", {24'd0, bus.RdData}, {24'd0, m_bank[bus.RdAddr]});
`ifdef REG_BANK_WRCOUNT_EN
        check_eq("WrCount", {24'd0, WrCount}, m_count % 256);
`endif
    endtask

    // One clock: model steps on the inputs seen at the edge, then outputs are checked.
    task automatic tick();
        bit ra, rb;
        ra = bus.ReqA;
        rb = bus.ReqB;
        @(posedge Clk);
        if (m_owner == 0) begin
            if (ra && (!rb || m_last == 2)) m_owner = 1;
            else if (rb)                    m_owner = 2;
            m_written = 0;
        end else if (!m_written) begin
            if (m_owner == 1) m_bank[bus.AddrA] = bus.DataA;
            else              m_bank[bus.AddrB] = bus.DataB;
            m_last    = m_owner;
            m_written = 1;
            m_count   = m_count + 1;
        end else if ((m_owner == 1 && !ra) || (m_owner == 2 && !rb)) begin
            m_owner = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        Resetn = 1'b0;
        bus.ReqA = 1'b0;
        bus.ReqB = 1'b0;
        #1;
        model_reset();
        check_eq("rst_GntA", {31'd0, bus.GntA}, 32'd0);
        check_eq("rst_GntB", {31'd0, bus.GntB}, 32'd0);
        check_eq("rst_Busy", {31'd0, bus.Busy}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.RdAddr = a[1:0];
            #1;
            check_eq("rst_RdData", {24'd0, bus.RdData}, 32'd0);
        end
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn    = 1'b1;
        bus.ReqA  = 1'b0;
        bus.AddrA = '0;
        bus.DataA = '0;
        bus.ReqB  = 1'b0;
        bus.AddrB = '0;
        bus.DataB = '0;
        bus.RdAddr = '0;
        @(posedge Clk);
        #1;
        async_reset();

        // Single write from A
        bus.RdAddr = 2'd2;
        bus.ReqA = 1'b1; bus.AddrA = 2'd2; bus.DataA = 8'h5A;
        tick();
        check_eq("single_gnt", {31'd0, bus.GntA}, 32'd1);
        tick();
        check_eq("single_wr", {24'd0, bus.RdData}, 32'h5A);
        tick();
        bus.ReqA = 1'b0;
        tick();
        check_eq("single_rel", {31'd0, bus.GntA}, 32'd0);
        tick();

        // Contention twice from reset: A, B, then A again
        async_reset();
        for (int r = 0; r < 2; r++) begin
            bus.ReqA = 1'b1; bus.ReqB = 1'b1;
            bus.AddrA = 2'd0; bus.DataA = 8'hA0 + r[7:0];
            bus.AddrB = 2'd3; bus.DataB = 8'hB0 + r[7:0];
            tick();
            check_eq("cont_first_A", {31'd0, bus.GntA}, 32'd1);
            tick(); tick();
            bus.ReqA = 1'b0;
            tick(); tick();
            check_eq("cont_then_B", {31'd0, bus.GntB}, 32'd1);
            tick();
            bus.ReqB = 1'b0;
            tick(); tick();
        end

        // Held B request with data changing every cycle
        bus.RdAddr = 2'd1; bus.AddrB = 2'd1;
        bus.ReqB = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.DataB = 8'($urandom);
            tick();
        end
        bus.ReqB = 1'b0;
        tick(); tick();

        // Read/write collision at address 1: 11 then FF
        bus.ReqA = 1'b1; bus.AddrA = 2'd1; bus.DataA = 8'h11;
        tick(); tick();
        bus.ReqA = 1'b0;
        tick(); tick();
        bus.ReqB = 1'b1; bus.AddrB = 2'd1; bus.DataB = 8'hFF;
        tick();
        check_eq("coll_old", {24'd0, bus.RdData}, 32'h11);
        tick();
        check_eq("coll_new", {24'd0, bus.RdData}, 32'hFF);
        bus.ReqB = 1'b0;
        tick(); tick();

        // Async reset while A sits in its wait phase
        bus.ReqA = 1'b1; bus.AddrA = 2'd3; bus.DataA = 8'h77;
        tick(); tick(); tick();
        async_reset();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            bus.ReqA   = ($urandom_range(0, 3) != 0);
            bus.ReqB   = ($urandom_range(0, 3) != 0);
            bus.AddrA  = 2'($urandom);
            bus.AddrB  = 2'($urandom);
            bus.DataA  = 8'($urandom);
            bus.DataB  = 8'($urandom);
            bus.RdAddr = 2'($urandom);
            tick();
        end

`ifdef REG_BANK_WRCOUNT_EN
        async_reset();
        for (int w = 0; w < 257; w++) begin
            bus.ReqA = 1'b1; bus.AddrA = 2'($urandom); bus.DataA = 8'($urandom);
            tick(); tick();
            bus.ReqA = 1'b0;
            tick();
        end
        check_eq("wrcount_wrap", {24'd0, WrCount}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
